// File: rtl/miner_core_pkg.sv
`default_nettype none
//==============================================================================
// Module      : miner_core_pkg
// Description : Shared definitions for the miner core SHA-256 datapath:
//               round constants K[0:63], the SHA-256 initial hash value,
//               the compression FSM state type and the bitwise helper
//               functions Sigma0, Sigma1, Ch and Maj.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//==============================================================================
package miner_core_pkg;

   // SHA-256 round constants, indexed by round number t.
   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // Initial hash value; word A in [255:224], word H in [31:0].
   localparam logic [255:0] SHA256_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_READY = 2'd2
   } comp_state_t;

   // Rotations are written as fixed concatenations so they map to wiring.
   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e,
                                      input logic [31:0] f,
                                      input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage : miner_core_pkg
`default_nettype wire

// File: rtl/miner_core_round.sv
`default_nettype none
//==============================================================================
// Module      : miner_core_round
// Description : One combinational SHA-256 compression round.
// Ports       : i_state  [255:0] working words a..h (a in [255:224])
//               i_w      [31:0]  schedule word W[t]
//               i_k      [31:0]  round constant K[t]
//               o_state  [255:0] next a..h, same word order
// Revision    : 1.0 - initial release
//==============================================================================
module miner_core_round
   import miner_core_pkg::*;
(
   input  logic [255:0] i_state,
   input  logic [31:0]  i_w,
   input  logic [31:0]  i_k,
   output logic [255:0] o_state
);

   logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
   logic [31:0] w_t1, w_t2;

   assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_state;

   assign w_t1 = w_h + big_sigma1(w_e) + ch(w_e, w_f, w_g) + i_k + i_w;
   assign w_t2 = big_sigma0(w_a) + maj(w_a, w_b, w_c);

   // Words shift down one slot; only a and e receive new values.
   assign o_state = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule : miner_core_round
`default_nettype wire

// File: rtl/miner_core_compress.sv
`default_nettype none
//==============================================================================
// Module      : miner_core_compress
// Description : SHA-256 compression datapath. Holds the working registers,
//               chain register, round counter, FSM and the final per-word
//               adder; one round per comp_en cycle.
// Ports       : clk, rst (async, active high)
//               init         load a..h and H from h_in, restart the block
//               h_in [255:0] initial chaining value (word A in [255:224])
//               comp_en      execute one round with w_in
//               w_in [31:0]  schedule word for the current round
//               add_en       final add: digest = H + a..h
//               round_cnt    index of the next round to execute
//               rounds_done  all rounds executed since the last init
//               digest       registered result, same word order as h_in
//               done         one-cycle pulse after an accepted add_en
// Revision    : 1.0 - initial release
//==============================================================================
module miner_core_compress
   import miner_core_pkg::*;
#(
   parameter int ROUNDS = 64
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      init,
   input  logic [255:0]              h_in,
   input  logic                      comp_en,
   input  logic [31:0]               w_in,
   input  logic                      add_en,
   output logic [$clog2(ROUNDS)-1:0] round_cnt,
   output logic                      rounds_done,
   output logic [255:0]              digest,
   output logic                      done
);

   localparam int               CNT_W        = $clog2(ROUNDS);
   localparam logic [CNT_W-1:0] C_LAST_ROUND = CNT_W'(ROUNDS - 1);

   comp_state_t       r_state;
   logic [255:0]      r_work;
   logic [255:0]      r_chain;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_rounds_done;
   logic [255:0]      r_digest;
   logic              r_done;

   logic [255:0]      w_next_work;
   logic [255:0]      w_sum;

   miner_core_round u_round (
      .i_state (r_work),
      .i_w     (w_in),
      .i_k     (K[6'(r_cnt)]),
      .o_state (w_next_work)
   );

   // Word-wise adder: each 32-bit lane wraps independently.
   for (genvar gi = 0; gi < 8; gi++) begin : g_word_add
      assign w_sum[gi*32 +: 32] = r_chain[gi*32 +: 32] + r_work[gi*32 +: 32];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_work        <= '0;
         r_chain       <= '0;
         r_cnt         <= '0;
         r_rounds_done <= 1'b0;
         r_digest      <= '0;
         r_done        <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (init) begin
            // init wins over any other strobe in any state.
            r_work        <= h_in;
            r_chain       <= h_in;
            r_cnt         <= '0;
            r_rounds_done <= 1'b0;
            r_state       <= ST_ROUND;
         end else begin
            case (r_state)
               ST_ROUND: begin
                  if (comp_en) begin
                     r_work <= w_next_work;
                     if (r_cnt == C_LAST_ROUND) begin
                        r_cnt         <= '0;
                        r_rounds_done <= 1'b1;
                        r_state       <= ST_READY;
                     end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end
                  end
               end
               ST_READY: begin
                  if (add_en) begin
                     r_digest <= w_sum;
                     r_chain  <= w_sum;
                     r_done   <= 1'b1;
                     r_state  <= ST_IDLE;
                  end
               end
               ST_IDLE: begin
                  // Wait for init; comp_en and add_en have no effect here.
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign round_cnt   = r_cnt;
   assign rounds_done = r_rounds_done;
   assign digest      = r_digest;
   assign done        = r_done;

endmodule : miner_core_compress
`default_nettype wire

// File: tb/tb_miner_core_compress.sv
`default_nettype none
//==============================================================================
// Module      : tb_miner_core_compress
// Description : Self-checking bench for miner_core_compress with a textbook
//               SHA-256 reference model, vector table and corner sequences.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_miner_core_compress;

   localparam logic [31:0] TB_K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [255:0] TB_IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         init = 1'b0;
   logic [255:0] h_in = '0;
   logic         comp_en = 1'b0;
   logic [31:0]  w_in = '0;
   logic         add_en = 1'b0;
   logic [5:0]   round_cnt;
   logic         rounds_done;
   logic [255:0] digest;
   logic         done;

   int n_pass  = 0;
   int n_total = 0;
   logic [31:0]  tb_w [64];
   logic [255:0] last_digest = '0;

   miner_core_compress #(.ROUNDS(64)) dut (
      .clk         (clk),
      .rst         (rst),
      .init        (init),
      .h_in        (h_in),
      .comp_en     (comp_en),
      .w_in        (w_in),
      .add_en      (add_en),
      .round_cnt   (round_cnt),
      .rounds_done (rounds_done),
      .digest      (digest),
      .done        (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic build_sched(input logic [511:0] blk);
      for (int t = 0; t < 64; t++) begin
         if (t < 16) tb_w[t] = blk[511 - 32*t -: 32];
         else tb_w[t] = tb_w[t-16] + tb_w[t-7]
                      + (rotr(tb_w[t-15], 7) ^ rotr(tb_w[t-15], 18) ^ (tb_w[t-15] >> 3))
                      + (rotr(tb_w[t-2], 17) ^ rotr(tb_w[t-2], 19) ^ (tb_w[t-2] >> 10));
      end
   endtask

   // Compression of the block currently in tb_w, starting from hv.
   function automatic logic [255:0] model_compress(input logic [255:0] hv);
      logic [31:0] v [8];
      logic [31:0] h0 [8];
      logic [31:0] t1, t2;
      logic [255:0] r;
      for (int i = 0; i < 8; i++) begin
         h0[i] = hv[255 - 32*i -: 32];
         v[i]  = h0[i];
      end
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TB_K[t] + tb_w[t];
         t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = h0[i] + v[i];
      return r;
   endfunction

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic do_init(input logic [255:0] hv);
      init = 1'b1; h_in = hv;
      tick();
      init = 1'b0; h_in = $urandom;
      chk("init round_cnt", round_cnt, 0);
      chk("init rounds_done", rounds_done, 0);
   endtask

   task automatic run_rounds(input int from, input int to, input int stall_pct);
      for (int t = from; t < to; t++) begin
         for (int s = 0; s < 4 && $urandom_range(99) < stall_pct; s++) begin
            comp_en = 1'b0; w_in = $urandom;
            tick();
            chk("stall round_cnt", round_cnt, t);
         end
         comp_en = 1'b1; w_in = tb_w[t];
         tick();
         comp_en = 1'b0; w_in = $urandom;
         chk("round_cnt", round_cnt, (t + 1) % 64);
         chk("rounds_done", rounds_done, (t == 63) ? 1 : 0);
      end
   endtask

   task automatic finish_block(input string name, input logic [255:0] exp);
      add_en = 1'b1;
      tick();
      add_en = 1'b0;
      chk({name, " done"}, done, 1);
      chk({name, " digest"}, digest, exp);
      last_digest = exp;
      tick();
      chk({name, " done pulse width"}, done, 0);
   endtask

   typedef struct {
      logic [255:0] hv;
      logic [511:0] blk;
      logic [255:0] exp;
      int           stall_pct;
   } vec_t;

   vec_t vecs [6];

   initial begin
      logic [511:0] rb;

      // Vector table: two known digests plus random blocks/chaining values.
      vecs[0] = '{TB_IV, BLK_EMPTY, DIG_EMPTY, 0};
      vecs[1] = '{TB_IV, BLK_ABC,   DIG_ABC,   0};
      vecs[2] = '{TB_IV, BLK_ABC,   DIG_ABC,   35};
      for (int i = 3; i < 6; i++) begin
         for (int j = 0; j < 16; j++) rb[511 - 32*j -: 32] = $urandom;
         vecs[i].blk = rb;
         vecs[i].hv  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         build_sched(rb);
         vecs[i].exp = model_compress(vecs[i].hv);
         vecs[i].stall_pct = 20;
      end

      // Reset state
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("reset round_cnt", round_cnt, 0);
      chk("reset rounds_done", rounds_done, 0);
      chk("reset done", done, 0);
      chk("reset digest", digest, 0);

      for (int i = 0; i < 6; i++) begin
         build_sched(vecs[i].blk);
         do_init(vecs[i].hv);
         run_rounds(0, 64, vecs[i].stall_pct);
         finish_block($sformatf("vec%0d", i), vecs[i].exp);
      end

      // add_en before the rounds complete is ignored
      build_sched(BLK_ABC);
      do_init(TB_IV);
      run_rounds(0, 30, 0);
      add_en = 1'b1;
      tick();
      add_en = 1'b0;
      chk("early add done", done, 0);
      chk("early add digest", digest, last_digest);
      chk("early add round_cnt", round_cnt, 30);
      run_rounds(30, 64, 0);
      // comp_en after rounds_done runs no extra round
      for (int i = 0; i < 3; i++) begin
         comp_en = 1'b1; w_in = $urandom;
         tick();
         comp_en = 1'b0;
         chk("late comp round_cnt", round_cnt, 0);
         chk("late comp rounds_done", rounds_done, 1);
      end
      finish_block("late comp", DIG_ABC);
      // add_en in IDLE is ignored
      add_en = 1'b1;
      tick();
      add_en = 1'b0;
      chk("idle add done", done, 0);
      chk("idle add digest", digest, last_digest);

      // init together with comp_en mid-block reloads without a round
      build_sched(BLK_EMPTY);
      do_init(TB_IV);
      run_rounds(0, 20, 0);
      build_sched(BLK_ABC);
      init = 1'b1; comp_en = 1'b1; h_in = TB_IV; w_in = tb_w[0];
      tick();
      init = 1'b0; comp_en = 1'b0;
      chk("reinit round_cnt", round_cnt, 0);
      chk("reinit rounds_done", rounds_done, 0);
      run_rounds(0, 64, 0);
      finish_block("reinit", DIG_ABC);

      // Asynchronous reset mid-block
      do_init(TB_IV);
      run_rounds(0, 40, 0);
      #2 rst = 1'b1;
      #1;
      chk("async rst round_cnt", round_cnt, 0);
      chk("async rst rounds_done", rounds_done, 0);
      chk("async rst digest", digest, 0);
      chk("async rst done", done, 0);
      tick();
      rst = 1'b0;
      last_digest = '0;
      // Without init, comp_en must not advance anything
      comp_en = 1'b1; w_in = $urandom;
      tick(); tick();
      comp_en = 1'b0;
      chk("post rst idle round_cnt", round_cnt, 0);
      chk("post rst digest", digest, 0);
      do_init(TB_IV);
      run_rounds(0, 64, 25);
      finish_block("post rst abc", DIG_ABC);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_miner_core_compress
`default_nettype wire
